// File: rtl/video_stream_pkg.sv
// Shared definitions for the camera AXI4-Stream video sink: raster defaults,
// decoder state encoding and framing-error causes.
package video_stream_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_ACTIVE = 1'b1
  } dec_state_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_EARLY_SOF  = 3'd1,
    ERR_SHORT_LINE = 3'd2,
    ERR_LONG_LINE  = 3'd3,
    ERR_NO_SOF     = 3'd4
  } err_cause_e;

endpackage

// File: rtl/axis_video_frame_decoder_tracker.sv
// axis_raster_tracker: holds the expected raster position of the next beat and
// classifies each evaluated beat against it (position to tag, drop, error).
module axis_raster_tracker
  import video_stream_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           beat,
  input  logic           sof,
  input  logic           eol,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           drop,
  output logic           err
);

  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           at_origin;
  logic           at_eol;
  logic           last_line;
  logic           long_line;
  err_cause_e     cause;

  // Classify the current beat; an SOF beat always lands on (0,0) before the EOL check.
  always_comb begin
    at_origin = (x_q == '0) && (y_q == '0);
    pos_x     = sof ? '0 : x_q;
    pos_y     = sof ? '0 : y_q;
    at_eol    = (pos_x == X_W'(H_ACTIVE - 1));
    last_line = (pos_y == Y_W'(V_ACTIVE - 1));
    long_line = 1'b0;
    cause     = ERR_NONE;
    if (!sof && at_origin) begin
      cause = ERR_NO_SOF;
    end else begin
      long_line = at_eol && !eol;
      if (sof && !at_origin)     cause = ERR_EARLY_SOF;
      else if (long_line)        cause = ERR_LONG_LINE;
      else if (eol && !at_eol)   cause = ERR_SHORT_LINE;
    end
    drop = (cause == ERR_NO_SOF) || long_line;
    err  = (cause != ERR_NONE);
  end

  // Advance the expected position; a dropped beat restarts the raster at (0,0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else if (beat) begin
      if (drop) begin
        x_q <= '0;
        y_q <= '0;
      end else if (eol) begin
        x_q <= '0;
        y_q <= last_line ? '0 : pos_y + Y_W'(1);
      end else begin
        x_q <= pos_x + X_W'(1);
        y_q <= pos_y;
      end
    end
  end

endmodule

// File: rtl/axis_video_frame_decoder.sv
// axis_video_frame_decoder: AXI4-Stream video sink that locks onto SOF, checks
// line/frame framing and tags every forwarded pixel with x/y coordinates.
// Optional FRAME_STATS_EN adds saturating frame_cnt / err_cnt outputs.
module axis_video_frame_decoder
  import video_stream_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int DATA_W   = 16,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tuser,
  input  logic              s_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [X_W-1:0]    m_x,
  output logic [Y_W-1:0]    m_y,
  output logic              m_sof,
  output logic              m_eof,
  output logic              sync_lost,
`ifdef FRAME_STATS_EN
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt,
`endif
  output logic              err_pulse
);

  dec_state_e     state_q;
  dec_state_e     state_d;
  logic           accept;
  logic           evaluate;
  logic           load;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic           drop;
  logic           err;

  axis_raster_tracker #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_tracker (
    .clk    (clk),
    .resetn (resetn),
    .beat   (evaluate),
    .sof    (s_tuser),
    .eol    (s_tlast),
    .pos_x  (pos_x),
    .pos_y  (pos_y),
    .drop   (drop),
    .err    (err)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_HUNT;
    else         state_q <= state_d;
  end

  // Next state and handshake. Ready only withholds while a registered beat is
  // stalled, so a beat pending on entry to HUNT is never overwritten.
  always_comb begin
    state_d  = state_q;
    s_tready = 1'b0;
    accept   = 1'b0;
    evaluate = 1'b0;
    load     = 1'b0;
    if (resetn) s_tready = !m_tvalid || m_tready;
    accept = s_tvalid && s_tready;
    case (state_q)
      ST_HUNT: begin
        evaluate = accept && s_tuser;
        if (evaluate && !drop) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        evaluate = accept;
        if (evaluate && drop) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
    load = evaluate && !drop;
  end

  assign sync_lost = (state_q == ST_HUNT);

  // Single output register: load on a kept beat, otherwise hold until taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_x      <= '0;
      m_y      <= '0;
      m_sof    <= 1'b0;
      m_eof    <= 1'b0;
    end else if (load) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
      m_x      <= pos_x;
      m_y      <= pos_y;
      m_sof    <= (pos_x == '0) && (pos_y == '0);
      m_eof    <= (pos_x == X_W'(H_ACTIVE - 1)) && (pos_y == Y_W'(V_ACTIVE - 1));
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // One strobe per erroneous beat, in the cycle after it was accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_pulse <= 1'b0;
    else         err_pulse <= evaluate && err;
  end

`ifdef FRAME_STATS_EN
  // Saturating statistics: completed frames and framing errors.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (m_tvalid && m_tready && m_eof && (frame_cnt != 16'hFFFF))
        frame_cnt <= frame_cnt + 16'd1;
      if (err_pulse && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
